axi_wr_burst_scheduler: RTL
===========================

// Module: axi_wr_burst_scheduler
// PURPOSE
//  Sequences the AXIS->AXI-full write master: arbitrates C_NUM_DEST per-tdest queues round-robin, issues one burst
//  command (addr/len/dest) at a time and waits for its B response. Each dest owns a DDR ring of C_SLOT_NUM slots,
//  one slot per burst. Tracks write pointer and occupancy per ring; slots are freed by the read-back side.
// PARAMETERS
//  C_M_TARGET_SLAVE_BASE_ADDR  32'h0  byte base of ring 0
//  C_M_AXI_ADDR_WIDTH          32     address width
//  C_M_AXI_DATA_WIDTH          64     data width; beat bytes = C_M_AXI_DATA_WIDTH/8
//  C_M_AXI_BURST_LEN           16     max beats per burst (power of 2, <=256); SLOT_BYTES = BURST_LEN*beat bytes
//  C_NUM_DEST                  8      requesters / rings (matches 3-bit tdest)
//  C_SLOT_NUM                  64     slots per ring (power of 2); REGION_BYTES = C_SLOT_NUM*SLOT_BYTES
// PORTS
//  M_AXI_ACLK      in   1            clock
//  M_AXI_ARESETN   in   1            async active-low reset
//  req_valid       in   NUM_DEST     queue d holds >=1 burst ready to write
//  req_len         in   NUM_DEST*8   per-queue AWLEN (beats-1), slice d = [8d+7:8d]
//  req_grant       out  NUM_DEST     one-hot 1-cycle pulse on command handshake; steers datapath to queue d
//  cmd_valid       out  1            burst command valid to write master
//  cmd_ready       in   1            write master accepts command
//  cmd_addr        out  ADDR_WIDTH   burst start byte address
//  cmd_len         out  8            AWLEN of burst
//  cmd_dest        out  3            dest index (clog2 NUM_DEST)
//  done_valid      in   1            B handshake completed for outstanding burst
//  done_resp       in   2            BRESP of that burst
//  rel_valid       in   1            read side frees oldest slot of ring rel_dest
//  rel_dest        in   3            ring to release
//  ring_full       out  NUM_DEST     count[d]==C_SLOT_NUM
//  ring_count_flat out  NUM_DEST*(clog2 SLOT_NUM+1)  occupancy per ring
//  wr_err          out  1            1-cycle pulse: done_resp!=2'b00 or release of empty ring
// BEHAVIOUR
//  Reset: cmd_valid=0, req_grant=0, wr_err=0, cmd_addr/len/dest=0, all wr_ptr=0, all count=0, rr pointer=0, FSM=IDLE.
//  Eligible(d) = req_valid[d] && !ring_full[d].
//  FSM IDLE: if any eligible -> ARB else stay.
//   ARB: pick first eligible at or after rr_ptr (wrap mod NUM_DEST); register
//        cmd_addr = BASE + d*REGION_BYTES + wr_ptr[d]*SLOT_BYTES, cmd_len=req_len[d], cmd_dest=d; -> CMD.
//        If no eligible anymore (req dropped) -> IDLE.
//   CMD: cmd_valid=1, fields stable until cmd_ready. On handshake: req_grant[d]=1 for that cycle,
//        count[d]+1, wr_ptr[d]+1 (wraps SLOT_NUM-1 -> 0), rr_ptr=d+1 mod NUM_DEST; -> WAIT_B.
//   WAIT_B: hold until done_valid; if done_resp!=OKAY pulse wr_err (slot stays committed); -> IDLE.
//  One burst outstanding max; min gap IDLE->cmd_valid is 2 cycles. done_valid outside WAIT_B ignored.
//  Slot reserved at command handshake, so ring_full reflects in-flight burst; partial burst occupies a full slot.
//  Release: rel_valid && count[rel_dest]>0 -> count-1 next cycle; count==0 -> ignored, wr_err pulse.
//  Same cycle commit+release on same ring: count unchanged; on different rings both apply.
//  Address arithmetic in ADDR_WIDTH, truncating; d*REGION_BYTES and slot offset are shift-only (power-of-2).
//  SLOT_BYTES divides 4096, so no burst crosses a 4 KB boundary.
//  Async reset mid-burst: FSM -> IDLE, pointers/counts cleared; downstream master is reset by same signal.
// STRUCTURE
//  Shared package: FSM state encoding (IDLE/ARB/CMD/WAIT_B), AXI_RESP_OKAY=2'b00,
//  SLOT_BYTES/REGION_BYTES/clog2 localparam functions.
//  One sub-module: rr_arbiter (NUM_DEST req + rr_ptr -> one-hot grant + index, combinational).
//  Per-ring wr_ptr/count as generate-loop registers in top.
// TESTING
//  1 Single req_valid[2], req_len=15, cmd_ready=1 -> cmd_addr=0x4000, len=15, dest=2, req_grant=0000_0100, count[2]=1.
//  2 req_valid=8'hFF held, done after each -> grant order 0,1,..,7,0; rr wraps; addr ring d slot k = d*0x2000+k*0x80.
//  3 64 bursts to dest 5, no release -> ring_full[5]=1, further req_valid[5] never granted; dest 6 still served.
//  4 Ring 3 at slot 63 write then release -> wr_ptr wraps to 0, next cmd_addr=0x6000; commit+release same cycle: count flat.
//  5 done_resp=2'b10 -> wr_err 1-cycle pulse, FSM->IDLE; rel_valid on empty ring -> wr_err, count stays 0.
//  6 Deassert ARESETN while in CMD with cmd_ready=0 -> cmd_valid=0 immediately, all counts 0, next grant from dest 0.

Source files
------------

// File: rtl/axi_wr_burst_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// axi_wr_burst_scheduler_pkg
//   Shared definitions for the AXI write burst scheduler:
//     - scheduler FSM state encoding
//     - AXI response code for OKAY
//     - constant functions for log2 and ring geometry (slot / region sizes)
// ----------------------------------------------------------------------------
package axi_wr_burst_scheduler_pkg;

  // Scheduler FSM states: wait for work, pick a queue, present the command,
  // wait for the write response of the single outstanding burst.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARB    = 2'd1,
    ST_CMD    = 2'd2,
    ST_WAIT_B = 2'd3
  } sched_state_e;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  // Ceiling log2, evaluated at elaboration time.
  function automatic int clog2_f(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  // Width of an index over 'value' items, never narrower than one bit.
  function automatic int idx_width_f(input int value);
    return (clog2_f(value) < 1) ? 1 : clog2_f(value);
  endfunction

  // One slot holds exactly one maximum-length burst.
  function automatic int slot_bytes_f(input int burst_len, input int data_width);
    return burst_len * (data_width / 8);
  endfunction

  // One ring region is the concatenation of all of its slots.
  function automatic int region_bytes_f(input int slot_num, input int slot_bytes);
    return slot_num * slot_bytes;
  endfunction

endpackage

// File: rtl/axi_wr_burst_scheduler_rr_arbiter.sv
// ----------------------------------------------------------------------------
// axi_wr_burst_scheduler_rr_arbiter
//   Purely combinational rotating-priority arbiter. The search starts at
//   rr_ptr and wraps modulo NUM_REQ; the first asserted request wins.
// Ports:
//   req        in   NUM_REQ   request vector (already qualified by caller)
//   rr_ptr     in   IDX_W     highest-priority requester this cycle
//   grant      out  NUM_REQ   one-hot winner (all zero if no request)
//   grant_idx  out  IDX_W     index of the winner
//   any_req    out  1         at least one request asserted
// ----------------------------------------------------------------------------
module axi_wr_burst_scheduler_rr_arbiter #(
  parameter int NUM_REQ = 8,
  parameter int IDX_W   = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_req
);

  int cand;

  // Walk the requesters in priority order starting at rr_ptr. Once a winner
  // has been found the any_req flag blocks every later candidate, which
  // keeps the grant strictly one-hot.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_req   = 1'b0;
    cand      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (int'(rr_ptr) + i) % NUM_REQ;
      if (!any_req && req[cand]) begin
        any_req     = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/axi_wr_burst_scheduler.sv
// ----------------------------------------------------------------------------
// axi_wr_burst_scheduler
//   Sequences an AXIS->AXI-full write master. Per-tdest queues are arbitrated
//   round-robin; one burst command is issued at a time and the scheduler then
//   waits for its B response. Every dest owns a DDR ring of C_SLOT_NUM slots
//   (one slot per burst); write pointer and occupancy are tracked per ring and
//   slots are freed by the read-back side.
// Ports:
//   M_AXI_ACLK       in   1                 clock
//   M_AXI_ARESETN    in   1                 async active-low reset
//   req_valid        in   NUM_DEST          queue d has a burst ready
//   req_len          in   NUM_DEST*8        per-queue AWLEN, slice d = [8d+7:8d]
//   req_grant        out  NUM_DEST          one-hot pulse on command handshake
//   cmd_valid        out  1                 burst command valid
//   cmd_ready        in   1                 write master accepts command
//   cmd_addr         out  ADDR_WIDTH        burst start byte address
//   cmd_len          out  8                 AWLEN of burst
//   cmd_dest         out  DEST_W            dest index of burst
//   done_valid       in   1                 B handshake of outstanding burst
//   done_resp        in   2                 BRESP of that burst
//   rel_valid        in   1                 read side frees oldest slot
//   rel_dest         in   DEST_W            ring to release
//   ring_full        out  NUM_DEST          ring occupancy == C_SLOT_NUM
//   ring_count_flat  out  NUM_DEST*CNT_W    occupancy per ring
//   wr_err           out  1                 error pulse (bad BRESP / bad release)
// ----------------------------------------------------------------------------
module axi_wr_burst_scheduler
  import axi_wr_burst_scheduler_pkg::*;
#(
  parameter logic [31:0] C_M_TARGET_SLAVE_BASE_ADDR = 32'h0,
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 64,
  parameter int C_M_AXI_BURST_LEN  = 16,
  parameter int C_NUM_DEST         = 8,
  parameter int C_SLOT_NUM         = 64,
  localparam int DEST_W = idx_width_f(C_NUM_DEST),
  localparam int CNT_W  = clog2_f(C_SLOT_NUM) + 1
) (
  input  logic                          M_AXI_ACLK,
  input  logic                          M_AXI_ARESETN,
  input  logic [C_NUM_DEST-1:0]         req_valid,
  input  logic [C_NUM_DEST*8-1:0]       req_len,
  output logic [C_NUM_DEST-1:0]         req_grant,
  output logic                          cmd_valid,
  input  logic                          cmd_ready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] cmd_addr,
  output logic [7:0]                    cmd_len,
  output logic [DEST_W-1:0]             cmd_dest,
  input  logic                          done_valid,
  input  logic [1:0]                    done_resp,
  input  logic                          rel_valid,
  input  logic [DEST_W-1:0]             rel_dest,
  output logic [C_NUM_DEST-1:0]         ring_full,
  output logic [C_NUM_DEST*CNT_W-1:0]   ring_count_flat,
  output logic                          wr_err
);

  localparam int AW           = C_M_AXI_ADDR_WIDTH;
  localparam int PTR_W        = idx_width_f(C_SLOT_NUM);
  localparam int SLOT_BYTES   = slot_bytes_f(C_M_AXI_BURST_LEN, C_M_AXI_DATA_WIDTH);
  localparam int REGION_BYTES = region_bytes_f(C_SLOT_NUM, SLOT_BYTES);
  localparam int SLOT_SHIFT   = clog2_f(SLOT_BYTES);
  localparam int REGION_SHIFT = clog2_f(REGION_BYTES);

  sched_state_e        state;
  logic [DEST_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]    wr_ptr [C_NUM_DEST];
  logic [CNT_W-1:0]    count  [C_NUM_DEST];

  logic [C_NUM_DEST-1:0] eligible;
  logic [C_NUM_DEST-1:0] arb_grant;
  logic [DEST_W-1:0]     arb_idx;
  logic                  arb_any;
  logic [7:0]            sel_len;
  logic [PTR_W-1:0]      sel_ptr;
  logic [AW-1:0]         next_addr;
  logic [DEST_W-1:0]     next_rr;
  logic                  cmd_fire;
  logic                  resp_bad;
  logic                  rel_bad;

  // A queue competes only if it has data and its ring still has a free slot.
  // Because the slot is reserved at command handshake, ring_full already
  // accounts for the burst that is in flight.
  assign eligible = req_valid & ~ring_full;

  axi_wr_burst_scheduler_rr_arbiter #(
    .NUM_REQ (C_NUM_DEST),
    .IDX_W   (DEST_W)
  ) u_rr_arbiter (
    .req       (eligible),
    .rr_ptr    (rr_ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_req   (arb_any)
  );

  // Pull the winner's burst length and current write slot out of the
  // per-queue vectors with a one-hot AND-OR select.
  always_comb begin
    sel_len = '0;
    sel_ptr = '0;
    for (int d = 0; d < C_NUM_DEST; d++) begin
      if (arb_grant[d]) begin
        sel_len = req_len[8*d +: 8];
        sel_ptr = wr_ptr[d];
      end
    end
  end

  // Ring regions and slots are powers of two, so the start address is the
  // base plus two shifted fields; the sum truncates to the address width.
  assign next_addr = AW'(C_M_TARGET_SLAVE_BASE_ADDR)
                   + (AW'(arb_idx) << REGION_SHIFT)
                   + (AW'(sel_ptr) << SLOT_SHIFT);

  // After a grant, priority moves to the dest just after the winner.
  assign next_rr = (cmd_dest == DEST_W'(C_NUM_DEST - 1)) ? '0 : cmd_dest + DEST_W'(1);

  assign cmd_fire = cmd_valid && cmd_ready;
  assign resp_bad = (state == ST_WAIT_B) && done_valid && (done_resp != AXI_RESP_OKAY);

  // The grant has to coincide with the handshake cycle so the datapath can
  // switch to the winning queue immediately; it is decoded from the
  // registered command dest qualified by cmd_ready.
  always_comb begin
    req_grant = '0;
    for (int d = 0; d < C_NUM_DEST; d++) begin
      req_grant[d] = cmd_fire && (cmd_dest == DEST_W'(d));
    end
  end

  // A release is an error if the named ring is empty or the dest index does
  // not name a ring at all; in both cases the counts are left alone.
  always_comb begin
    rel_bad = rel_valid;
    for (int d = 0; d < C_NUM_DEST; d++) begin
      if (rel_dest == DEST_W'(d)) begin
        rel_bad = rel_valid && (count[d] == '0);
      end
    end
  end

  // Main scheduler FSM. Command fields are latched in ARB and held stable
  // throughout CMD until the master accepts them. Only one burst is ever
  // outstanding; done_valid is ignored outside WAIT_B. A failing BRESP
  // does not roll back the slot, the burst stays committed.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state     <= ST_IDLE;
      cmd_valid <= 1'b0;
      cmd_addr  <= '0;
      cmd_len   <= '0;
      cmd_dest  <= '0;
      rr_ptr    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arb_any) begin
            state <= ST_ARB;
          end
        end
        ST_ARB: begin
          if (arb_any) begin
            cmd_addr  <= next_addr;
            cmd_len   <= sel_len;
            cmd_dest  <= arb_idx;
            cmd_valid <= 1'b1;
            state     <= ST_CMD;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_CMD: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            rr_ptr    <= next_rr;
            state     <= ST_WAIT_B;
          end
        end
        ST_WAIT_B: begin
          if (done_valid) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Error pulse lasts exactly one cycle per offending event.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      wr_err <= 1'b0;
    end else begin
      wr_err <= resp_bad || rel_bad;
    end
  end

  // Per-ring write pointer and occupancy. A commit and a release on the same
  // ring in one cycle cancel out; the write pointer advances on every commit
  // and wraps from the last slot back to slot 0.
  for (genvar g = 0; g < C_NUM_DEST; g++) begin : g_ring
    logic ring_commit;
    logic ring_release;

    assign ring_commit  = cmd_fire && (cmd_dest == DEST_W'(g));
    assign ring_release = rel_valid && (rel_dest == DEST_W'(g)) && (count[g] != '0);

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
      if (!M_AXI_ARESETN) begin
        wr_ptr[g] <= '0;
        count[g]  <= '0;
      end else begin
        if (ring_commit) begin
          if (wr_ptr[g] == PTR_W'(C_SLOT_NUM - 1)) begin
            wr_ptr[g] <= '0;
          end else begin
            wr_ptr[g] <= wr_ptr[g] + PTR_W'(1);
          end
        end
        if (ring_commit && !ring_release) begin
          count[g] <= count[g] + CNT_W'(1);
        end else if (!ring_commit && ring_release) begin
          count[g] <= count[g] - CNT_W'(1);
        end
      end
    end

    assign ring_full[g]                      = (count[g] == CNT_W'(C_SLOT_NUM));
    assign ring_count_flat[g*CNT_W +: CNT_W] = count[g];
  end

endmodule
